// File: rtl/my_converter_64_2_256.sv
// 64-to-256 AXI4-Stream packer: four beats per word, lane 0 in the low bits, packets never share a word.
// Word is registered on the edge accepting its completing beat; input stalls while the output word is held.
module my_converter_64_2_256 #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 64,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                              axi_aclk,
    input  logic                              axi_reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast
);
    localparam int SW = C_S_AXIS_DATA_WIDTH;
    localparam int SB = C_S_AXIS_DATA_WIDTH / 8;
    localparam int MW = C_M_AXIS_DATA_WIDTH;
    localparam int MB = C_M_AXIS_DATA_WIDTH / 8;

    logic [1:0]                        lane_q, lane_d;
    logic [3*SW-1:0]                   acc_data_q, acc_data_d;
    logic [3*SB-1:0]                   acc_strb_q, acc_strb_d;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]   acc_user_q, acc_user_d;
    logic [MW-1:0]                     m_data_q, m_data_d;
    logic [MB-1:0]                     m_strb_q, m_strb_d;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_user_q, m_user_d;
    logic                              m_vld_q, m_vld_d;
    logic                              m_last_q, m_last_d;

    logic          accept;
    logic          complete;
    logic [MW-1:0] word_data;
    logic [MB-1:0] word_strb;

    assign s_axis_tready = !axi_reset && (!m_vld_q || m_axis_tready);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign complete      = accept && (s_axis_tlast || lane_q == 2'd3);

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tstrb  = m_strb_q;
    assign m_axis_tuser  = m_user_q;
    assign m_axis_tvalid = m_vld_q;
    assign m_axis_tlast  = m_last_q;

    // Slots above the current lane stay zero, which also hides stale accumulator content.
    always_comb begin
        word_data = '0;
        word_strb = '0;
        for (int i = 0; i < 3; i++) begin
            if (lane_q > 2'(i)) begin
                word_data[i*SW +: SW] = acc_data_q[i*SW +: SW];
                word_strb[i*SB +: SB] = acc_strb_q[i*SB +: SB];
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (lane_q == 2'(i)) begin
                word_data[i*SW +: SW] = s_axis_tdata;
                word_strb[i*SB +: SB] = s_axis_tstrb;
            end
        end
    end

    always_comb begin
        lane_d     = lane_q;
        acc_data_d = acc_data_q;
        acc_strb_d = acc_strb_q;
        acc_user_d = acc_user_q;
        m_data_d   = m_data_q;
        m_strb_d   = m_strb_q;
        m_user_d   = m_user_q;
        m_vld_d    = m_vld_q;
        m_last_d   = m_last_q;

        if (m_vld_q && m_axis_tready) begin
            m_vld_d = 1'b0;
        end

        if (complete) begin
            lane_d   = 2'd0;
            m_data_d = word_data;
            m_strb_d = word_strb;
            m_user_d = (lane_q == 2'd0) ? s_axis_tuser : acc_user_q;
            m_last_d = s_axis_tlast;
            m_vld_d  = 1'b1;
        end else if (accept) begin
            lane_d = lane_q + 2'd1;
            for (int i = 0; i < 3; i++) begin
                if (lane_q == 2'(i)) begin
                    acc_data_d[i*SW +: SW] = s_axis_tdata;
                    acc_strb_d[i*SB +: SB] = s_axis_tstrb;
                end
            end
            if (lane_q == 2'd0) begin
                acc_user_d = s_axis_tuser;
            end
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            lane_q     <= '0;
            acc_data_q <= '0;
            acc_strb_q <= '0;
            acc_user_q <= '0;
            m_data_q   <= '0;
            m_strb_q   <= '0;
            m_user_q   <= '0;
            m_vld_q    <= 1'b0;
            m_last_q   <= 1'b0;
        end else begin
            lane_q     <= lane_d;
            acc_data_q <= acc_data_d;
            acc_strb_q <= acc_strb_d;
            acc_user_q <= acc_user_d;
            m_data_q   <= m_data_d;
            m_strb_q   <= m_strb_d;
            m_user_q   <= m_user_d;
            m_vld_q    <= m_vld_d;
            m_last_q   <= m_last_d;
        end
    end
endmodule

// File: tb/tb_my_converter_64_2_256.sv
// Directed bench for the 64-to-256 packer; inputs change and outputs are sampled on the falling edge.
module tb_my_converter_64_2_256;
    logic         clk;
    logic         rst;
    logic [63:0]  s_tdata;
    logic [7:0]   s_tstrb;
    logic [127:0] s_tuser;
    logic         s_tvalid;
    logic         s_tready;
    logic         s_tlast;
    logic [255:0] m_tdata;
    logic [31:0]  m_tstrb;
    logic [127:0] m_tuser;
    logic         m_tvalid;
    logic         m_tready;
    logic         m_tlast;

    int total = 0;
    int bad   = 0;

    my_converter_64_2_256 dut (
        .axi_aclk      (clk),
        .axi_reset     (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [255:0] d, input logic [31:0] s,
                        input logic [127:0] u, input logic l);
        chk({tag, ".vld"},  256'(m_tvalid), 256'(1'b1));
        chk({tag, ".data"}, m_tdata, d);
        chk({tag, ".strb"}, 256'(m_tstrb), 256'(s));
        chk({tag, ".user"}, 256'(m_tuser), 256'(u));
        chk({tag, ".last"}, 256'(m_tlast), 256'(l));
    endtask

    // Presents one beat that must be accepted on the next rising edge.
    task automatic beat(input logic [63:0] d, input logic [7:0] s, input logic [127:0] u, input logic l);
        s_tdata  = d;
        s_tstrb  = s;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        #1;
        chk("beat.rdy", 256'(s_tready), 256'(1'b1));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, ".vld"},  256'(m_tvalid), 256'(0));
        chk({tag, ".data"}, m_tdata, 256'(0));
        chk({tag, ".strb"}, 256'(m_tstrb), 256'(0));
        chk({tag, ".user"}, 256'(m_tuser), 256'(0));
        chk({tag, ".last"}, 256'(m_tlast), 256'(0));
        chk({tag, ".srdy"}, 256'(s_tready), 256'(0));
    endtask

    initial begin
        logic [255:0] w1;
        logic [255:0] exp_w;
        logic [63:0]  d;

        rst = 1'b1; s_tdata = '0; s_tstrb = '0; s_tuser = '0;
        s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b0;

        // 4-beat packet
        beat(64'h1, 8'hFF, 128'h1111, 1'b0); chk("p4.b0.vld", 256'(m_tvalid), 256'(0));
        beat(64'h2, 8'hFF, 128'h0EEE, 1'b0); chk("p4.b1.vld", 256'(m_tvalid), 256'(0));
        beat(64'h3, 8'hFF, 128'h0EEE, 1'b0); chk("p4.b2.vld", 256'(m_tvalid), 256'(0));
        beat(64'h4, 8'hFF, 128'h0EEE, 1'b1);
        chkw("p4", {64'h4, 64'h3, 64'h2, 64'h1}, 32'hFFFFFFFF, 128'h1111, 1'b1);
        idle(); chk("p4.drain", 256'(m_tvalid), 256'(0));

        // 6-beat packet, short final word
        beat(64'hA0, 8'hFF, 128'h2222, 1'b0);
        beat(64'hA1, 8'hFF, 128'h0009, 1'b0);
        beat(64'hA2, 8'hFF, 128'h0009, 1'b0);
        beat(64'hA3, 8'hFF, 128'h0009, 1'b0);
        chkw("p6.w1", {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 32'hFFFFFFFF, 128'h2222, 1'b0);
        beat(64'hA4, 8'hFF, 128'h3333, 1'b0); chk("p6.b4.vld", 256'(m_tvalid), 256'(0));
        beat(64'hA5, 8'h0F, 128'h0009, 1'b1);
        chkw("p6.w2", {128'h0, 64'hA5, 64'hA4}, 32'h00000FFF, 128'h3333, 1'b1);
        idle();

        // 1-beat packet
        beat(64'hDEADBEEF_CAFEF00D, 8'h03, 128'hABCD, 1'b1);
        chkw("p1", {192'h0, 64'hDEADBEEF_CAFEF00D}, 32'h00000003, 128'hABCD, 1'b1);
        idle();

        // 12-beat packet with a 10-cycle output stall after word 1
        beat(64'hB000, 8'hFF, 128'hB0, 1'b0);
        beat(64'hB001, 8'hFF, 128'hEE, 1'b0);
        beat(64'hB002, 8'hFF, 128'hEE, 1'b0);
        beat(64'hB003, 8'hFF, 128'hEE, 1'b0);
        w1 = {64'hB003, 64'hB002, 64'hB001, 64'hB000};
        chkw("bp.w1", w1, 32'hFFFFFFFF, 128'hB0, 1'b0);
        m_tready = 1'b0;
        s_tdata = 64'hB004; s_tstrb = 8'hFF; s_tuser = 128'hB4; s_tlast = 1'b0; s_tvalid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp.srdy", 256'(s_tready), 256'(0));
            chk("bp.vld",  256'(m_tvalid), 256'(1));
            chk("bp.data", m_tdata, w1);
            chk("bp.user", 256'(m_tuser), 256'(128'hB0));
        end
        m_tready = 1'b1;
        beat(64'hB004, 8'hFF, 128'hB4, 1'b0); chk("bp.b4.vld", 256'(m_tvalid), 256'(0));
        beat(64'hB005, 8'hFF, 128'hEE, 1'b0);
        beat(64'hB006, 8'hFF, 128'hEE, 1'b0);
        beat(64'hB007, 8'hFF, 128'hEE, 1'b0);
        chkw("bp.w2", {64'hB007, 64'hB006, 64'hB005, 64'hB004}, 32'hFFFFFFFF, 128'hB4, 1'b0);
        beat(64'hB008, 8'hFF, 128'hB8, 1'b0); chk("bp.b8.vld", 256'(m_tvalid), 256'(0));
        beat(64'hB009, 8'hFF, 128'hEE, 1'b0);
        beat(64'hB00A, 8'hFF, 128'hEE, 1'b0);
        beat(64'hB00B, 8'hFF, 128'hEE, 1'b1);
        chkw("bp.w3", {64'hB00B, 64'hB00A, 64'hB009, 64'hB008}, 32'hFFFFFFFF, 128'hB8, 1'b1);
        idle();

        // 16 back-to-back beats, 4 packets of 4
        for (int p = 0; p < 4; p++) begin
            exp_w = '0;
            for (int b = 0; b < 4; b++) begin
                d = 64'h5000 + 64'(p * 16 + b);
                exp_w[b*64 +: 64] = d;
                beat(d, 8'hFF, (b == 0) ? 128'h500 + 128'(p) : 128'hEE, b == 3);
                if (b != 3) chk("tp.gap", 256'(m_tvalid), 256'(0));
            end
            chkw("tp.word", exp_w, 32'hFFFFFFFF, 128'h500 + 128'(p), 1'b1);
        end

        // Asynchronous reset after two beats of a packet
        beat(64'hC0, 8'hFF, 128'hC0, 1'b0);
        beat(64'hC1, 8'hFF, 128'hC1, 1'b0);
        #2 rst = 1'b1;
        #1 chk_zero_outputs("arst");
        s_tvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        beat(64'hD0, 8'hFF, 128'hD0, 1'b0);
        beat(64'hD1, 8'hFF, 128'hD1, 1'b0);
        beat(64'hD2, 8'hFF, 128'hD2, 1'b0);
        beat(64'hD3, 8'hFF, 128'hD3, 1'b1);
        chkw("post", {64'hD3, 64'hD2, 64'hD1, 64'hD0}, 32'hFFFFFFFF, 128'hD0, 1'b1);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/my_converter_64_2_256.md
# my_converter_64_2_256

Width up-converter: packs a 64-bit AXI4-Stream into a 256-bit AXI4-Stream, four input beats per output word, lane 0 in bits [63:0]. It is the receive-direction counterpart of the 256-to-64 down-converter: it packs 64-bit beats coming from the MAC/port side into 256-bit words for the DMA engine. Packet boundaries are preserved, so a word never mixes two packets. Buffering is one accumulator plus one output register; there is no FIFO.

## Interface
- C_M_AXIS_DATA_WIDTH, 256, output data width (fixed at 256)
- C_S_AXIS_DATA_WIDTH, 64, input data width (fixed at 64)
- C_M_AXIS_TUSER_WIDTH, 128, output tuser width
- C_S_AXIS_TUSER_WIDTH, 128, input tuser width
- axi_aclk  in  1  sole clock, rising edge
- axi_reset  in  1  asynchronous, active-high reset
- s_axis_tdata  in  64  input data
- s_axis_tstrb  in  8  input byte strobes
- s_axis_tuser  in  128  input sideband
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  last beat of packet
- m_axis_tdata  out  256  output data, registered
- m_axis_tstrb  out  32  output byte strobes, registered
- m_axis_tuser  out  128  output sideband, registered
- m_axis_tvalid  out  1  output valid, registered
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  last word of packet, registered

## Operation
- State:
  - lane: 2-bit counter, 0..3.
  - Accumulator: acc_data[191:0], acc_strb[23:0] and acc_user, holding lanes 0–2.
  - Output register: all m_axis_* signals.
- Input accept: accept = s_axis_tvalid && s_axis_tready.
- s_axis_tready = !axi_reset && (!m_axis_tvalid || m_axis_tready).
  - The input stalls whenever the output register is occupied and not draining, including for non-completing beats.
- Non-completing beat (accept && !s_axis_tlast && lane != 3):
  - Write tdata and tstrb into accumulator lane `lane`.
  - If lane == 0, capture s_axis_tuser into acc_user.
  - lane <= lane + 1.
- Completing beat (accept && (s_axis_tlast || lane == 3)): load the output register and set lane <= 0.
  - m_axis_tdata: lane slot = input beat, lower slots = accumulator, higher slots = 0.
  - m_axis_tstrb: same slot mapping; higher slots = 0.
  - m_axis_tuser = s_axis_tuser if lane == 0, else acc_user.
  - m_axis_tlast = s_axis_tlast.
  - m_axis_tvalid <= 1.
- Output drain: when m_axis_tvalid && m_axis_tready and there is no completing beat in the same cycle, m_axis_tvalid <= 0. Data fields hold their last value.
- Simultaneous drain and completing beat: the output register reloads with the new word and m_axis_tvalid stays 1, so there is no bubble.
- Input tstrb is passed through unchecked.
  - A beat with tstrb == 0 still occupies a lane.
  - The packet-end lane is set by tlast, not by strobes.
- Unfilled lanes of a short last word are zero in both data and strobe.
- The accumulator is not cleared after a completing beat. Stale content is never emitted, because slot mapping zeroes every slot above the current lane.

## Timing
- Latency: a word appears on m_axis_* on the clock edge that accepts its completing beat, i.e. valid in the following cycle.
- Throughput: one input beat per cycle sustained when m_axis_tready is held at 1. The output then carries one word per 4 cycles, or fewer for short packets.
- While m_axis_tvalid = 1 and m_axis_tready = 0, all m_axis_* outputs are stable, as AXIS requires.
- s_axis_tready has a combinational path from m_axis_tready and does not depend on s_axis_tvalid.
- Reset, asynchronous on assert and effective immediately:
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tstrb = 0, m_axis_tuser = 0, m_axis_tlast = 0.
  - lane = 0, accumulator = 0.
  - s_axis_tready = 0 while axi_reset = 1.
- Reset mid-packet discards the partial word and any unsent output word. The first beat after deassertion goes to lane 0.
- Deassertion is treated as synchronous to axi_aclk by upstream reset logic. The first accept can occur on the first rising edge after deassertion.

## Test plan
- 4-beat packet, beats D0..D3 = 64'h0..01 .. 64'h0..04, strb 0xFF, tlast on D3, m_axis_tready = 1 → one word tdata = {D3,D2,D1,D0}, tstrb = 32'hFFFFFFFF, tlast = 1, valid exactly one cycle after D3 is accepted.
- 6-beat packet, last beat strb 0x0F → word 1 has tstrb = 32'hFFFFFFFF and tlast = 0. Word 2 has tdata[127:0] = {D5,D4}, tdata[255:128] = 0, tstrb = 32'h00000FFF, tlast = 1.
- 1-beat packet, tuser = 128'hABCD, strb 0x03, tlast = 1 → tdata[63:0] = D0, upper bits 0, tstrb = 32'h00000003, tuser = 128'hABCD, tlast = 1.
- Backpressure: hold m_axis_tready = 0 after word 1 of a 12-beat stream → s_axis_tready = 0 and m_axis_* stable for 10 cycles. Release → all 3 words arrive in order, no loss or duplication, and tuser per word equals the tuser of its lane-0 beat.
- Throughput: 16 back-to-back beats (4 packets of 4) with m_axis_tready = 1 → s_axis_tready never drops and 4 words are produced at 4-cycle spacing.
- Assert axi_reset asynchronously, between clock edges, after 2 beats of a packet → m_axis_tvalid goes to 0 before the next edge and all outputs read 0. A following 4-beat packet yields a word with D0 in lane 0 and no residue from the aborted packet.
